// File: rtl/data_memory_access_controller.sv
// MEM-stage sequencer for the multi-cycle data memory: one req/ready handshake per access.
// Optional wait timeout with sticky mem_error when DMEM_TIMEOUT_EN is defined.
module data_memory_access_controller #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  signal_read_data_memory,
    input  logic                  signal_write_data_memory,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  stall_pipeline,
    output logic [DATA_WIDTH-1:0] out_read_data,
    output logic                  out_read_data_valid,
    output logic                  mem_error
);

    typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, COMPLETE} state_t;

    state_t                state, state_next;
    logic                  req_next, we_next, valid_next;
    logic [ADDR_WIDTH-1:0] address_next;
    logic [DATA_WIDTH-1:0] write_data_next, read_data_next;
    logic                  waiting;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must lie in 2..255");
    end

    assign waiting = (state == READ_WAIT) || (state == WRITE_WAIT);

    // Stall in the request cycle itself so EX/MEM keeps the instruction
    assign stall_pipeline = (state == IDLE && (signal_read_data_memory || signal_write_data_memory))
                            || waiting;

`ifdef DMEM_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wait_count, wait_count_next;
    logic       error_next, timeout_hit;

    assign timeout_hit = waiting && !mem_ready && (wait_count == TIMEOUT_LAST);
`endif

    always_comb begin
        state_next      = state;
        req_next        = mem_req;
        we_next         = mem_we;
        address_next    = mem_address;
        write_data_next = mem_write_data;
        read_data_next  = out_read_data;
        valid_next      = 1'b0;
`ifdef DMEM_TIMEOUT_EN
        wait_count_next = wait_count;
        error_next      = mem_error;
`endif
        case (state)
            IDLE: begin
                if (signal_write_data_memory) begin
                    address_next    = address;
                    write_data_next = write_data;
                    req_next        = 1'b1;
                    we_next         = 1'b1;
                    state_next      = WRITE_WAIT;
`ifdef DMEM_TIMEOUT_EN
                    wait_count_next = '0;
`endif
                end else if (signal_read_data_memory) begin
                    address_next    = address;
                    req_next        = 1'b1;
                    we_next         = 1'b0;
                    state_next      = READ_WAIT;
`ifdef DMEM_TIMEOUT_EN
                    wait_count_next = '0;
`endif
                end
            end
            READ_WAIT, WRITE_WAIT: begin
                if (mem_ready) begin
                    req_next   = 1'b0;
                    state_next = COMPLETE;
                    if (state == READ_WAIT) begin
                        read_data_next = mem_read_data;
                        valid_next     = 1'b1;
                    end
                end
`ifdef DMEM_TIMEOUT_EN
                else if (timeout_hit) begin
                    req_next   = 1'b0;
                    error_next = 1'b1;
                    state_next = COMPLETE;
                    if (state == READ_WAIT) begin
                        read_data_next = '0;
                        valid_next     = 1'b1;
                    end
                end else begin
                    wait_count_next = wait_count + 8'd1;
                end
`endif
            end
            // rd/wr still belong to the finishing instruction here
            COMPLETE: state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state               <= IDLE;
            mem_req             <= 1'b0;
            mem_we              <= 1'b0;
            mem_address         <= '0;
            mem_write_data      <= '0;
            out_read_data       <= '0;
            out_read_data_valid <= 1'b0;
        end else begin
            state               <= state_next;
            mem_req             <= req_next;
            mem_we              <= we_next;
            mem_address         <= address_next;
            mem_write_data      <= write_data_next;
            out_read_data       <= read_data_next;
            out_read_data_valid <= valid_next;
        end
    end

`ifdef DMEM_TIMEOUT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_count <= '0;
            mem_error  <= 1'b0;
        end else begin
            wait_count <= wait_count_next;
            mem_error  <= error_next;
        end
    end
`else
    assign mem_error = 1'b0;
`endif

endmodule
